// File: rtl/hamming_hakem.sv
`default_nettype none
// ============================================================================
//  Module   : hamming_hakem
//  Purpose  : Two-requester arbiter in front of one shared 32-bit Hamming
//             distance datapath. Round-robin grant, operand latch, one
//             registered result slot with valid/ready handshake back to the
//             granted requester.
//  Ports    : clk_i, rst_ni (async, active-low)
//             istekN_gecerli_i / istekN_hazir_o / istekN_deger{1,2}_i
//                 operand handshake for requester N (0 = X-instr, 1 = crypto)
//             sonucN_gecerli_o / sonucN_hazir_i
//                 result handshake for requester N
//             sonuc_o        shared 6-bit distance bus (0..32)
//             islem_sayisi_o completed-operation counter
//  Options  : define HAMMING_HAKEM_SAYAC_EN to build the saturating
//             operation counter; otherwise islem_sayisi_o is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================

// Population count of the XOR of two 32-bit words.
module hamming_distance (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [5:0]  o_mesafe
);
    logic [31:0] w_fark;

    always_comb begin
        w_fark   = i_a ^ i_b;
        o_mesafe = '0;
        for (int i = 0; i < 32; i++) begin
            o_mesafe = o_mesafe + {5'd0, w_fark[i]};
        end
    end
endmodule

module hamming_hakem #(
    parameter int SAYAC_GENISLIGI = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       istek0_gecerli_i,
    output logic                       istek0_hazir_o,
    input  logic [31:0]                istek0_deger1_i,
    input  logic [31:0]                istek0_deger2_i,
    input  logic                       istek1_gecerli_i,
    output logic                       istek1_hazir_o,
    input  logic [31:0]                istek1_deger1_i,
    input  logic [31:0]                istek1_deger2_i,
    output logic                       sonuc0_gecerli_o,
    output logic                       sonuc1_gecerli_o,
    input  logic                       sonuc0_hazir_i,
    input  logic                       sonuc1_hazir_i,
    output logic [5:0]                 sonuc_o,
    output logic [SAYAC_GENISLIGI-1:0] islem_sayisi_o
);
    localparam logic [1:0] C_BOSTA   = 2'd0;
    localparam logic [1:0] C_HESAPLA = 2'd1;
    localparam logic [1:0] C_SONUC   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        ptr_q, ptr_d;       // preferred requester on a tie
    logic        grant_q, grant_d;   // requester owning the current operation
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [5:0]  sonuc_q, sonuc_d;

    logic        w_herhangi;
    logic        w_secim;
    logic        w_tuketildi;
    logic [5:0]  w_mesafe;

    hamming_distance u_hd (
        .i_a      (op1_q),
        .i_b      (op2_q),
        .o_mesafe (w_mesafe)
    );

    assign w_herhangi  = istek0_gecerli_i | istek1_gecerli_i;
    // Pointer only matters on a tie; a lone requester wins outright.
    assign w_secim     = (istek0_gecerli_i & istek1_gecerli_i) ? ptr_q : istek1_gecerli_i;
    // Only the owner's ready counts; the other requester's ready is ignored.
    assign w_tuketildi = (state_q == C_SONUC) & (grant_q ? sonuc1_hazir_i : sonuc0_hazir_i);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        sonuc_d = sonuc_q;
        case (state_q)
            C_BOSTA: begin
                if (w_herhangi) begin
                    grant_d = w_secim;
                    ptr_d   = ~w_secim;
                    op1_d   = w_secim ? istek1_deger1_i : istek0_deger1_i;
                    op2_d   = w_secim ? istek1_deger2_i : istek0_deger2_i;
                    state_d = C_HESAPLA;
                end
            end
            C_HESAPLA: begin
                sonuc_d = w_mesafe;
                state_d = C_SONUC;
            end
            C_SONUC: begin
                // Return to idle only; the next grant happens one cycle later.
                if (w_tuketildi) begin
                    state_d = C_BOSTA;
                end
            end
            default: state_d = C_BOSTA;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= C_BOSTA;
            ptr_q   <= 1'b0;
            grant_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            sonuc_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sonuc_q <= sonuc_d;
        end
    end

    // Ready is combinational from the valids; gating with rst_ni keeps it
    // low while reset is held even if requesters keep their valids high.
    assign istek0_hazir_o   = rst_ni & (state_q == C_BOSTA) & w_herhangi & ~w_secim;
    assign istek1_hazir_o   = rst_ni & (state_q == C_BOSTA) & w_herhangi &  w_secim;
    assign sonuc0_gecerli_o = (state_q == C_SONUC) & ~grant_q;
    assign sonuc1_gecerli_o = (state_q == C_SONUC) &  grant_q;
    assign sonuc_o          = sonuc_q;

`ifdef HAMMING_HAKEM_SAYAC_EN
    logic [SAYAC_GENISLIGI-1:0] sayac_q, sayac_d;

    always_comb begin
        sayac_d = sayac_q;
        if (w_tuketildi && (sayac_q != {SAYAC_GENISLIGI{1'b1}})) begin
            sayac_d = sayac_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sayac_q <= '0;
        end else begin
            sayac_q <= sayac_d;
        end
    end

    assign islem_sayisi_o = sayac_q;
`else
    assign islem_sayisi_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hamming_hakem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hamming_hakem
//  Purpose  : Self-checking bench for hamming_hakem. Transaction-level
//             reference: distance = popcount(a ^ b), round-robin tie winner,
//             saturating operation count (when HAMMING_HAKEM_SAYAC_EN is set).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hamming_hakem;
    localparam int W = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          istek0_gecerli_i, istek1_gecerli_i;
    logic          istek0_hazir_o, istek1_hazir_o;
    logic [31:0]   istek0_deger1_i, istek0_deger2_i;
    logic [31:0]   istek1_deger1_i, istek1_deger2_i;
    logic          sonuc0_gecerli_o, sonuc1_gecerli_o;
    logic          sonuc0_hazir_i, sonuc1_hazir_i;
    logic [5:0]    sonuc_o;
    logic [W-1:0]  islem_sayisi_o;

    int checks = 0;
    int errors = 0;

    // Reference state (transaction level)
    int         m_ptr;      // tie winner for next grant
    int         m_ops;      // completed handshakes since reset
    logic [5:0] m_last;     // last delivered result

    hamming_hakem #(.SAYAC_GENISLIGI(W)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .istek0_gecerli_i (istek0_gecerli_i),
        .istek0_hazir_o   (istek0_hazir_o),
        .istek0_deger1_i  (istek0_deger1_i),
        .istek0_deger2_i  (istek0_deger2_i),
        .istek1_gecerli_i (istek1_gecerli_i),
        .istek1_hazir_o   (istek1_hazir_o),
        .istek1_deger1_i  (istek1_deger1_i),
        .istek1_deger2_i  (istek1_deger2_i),
        .sonuc0_gecerli_o (sonuc0_gecerli_o),
        .sonuc1_gecerli_o (sonuc1_gecerli_o),
        .sonuc0_hazir_i   (sonuc0_hazir_i),
        .sonuc1_hazir_i   (sonuc1_hazir_i),
        .sonuc_o          (sonuc_o),
        .islem_sayisi_o   (islem_sayisi_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp();
`ifdef HAMMING_HAKEM_SAYAC_EN
        cnt_exp = (m_ops > (2**W - 1)) ? (2**W - 1) : m_ops;
`else
        cnt_exp = 0;
`endif
    endfunction

    // One full transaction starting at a negedge with the DUT idle.
    // c1/c2 replace every operand right after the grant; bp = stall cycles.
    task automatic op(input logic v0, input logic v1,
                      input logic [31:0] a0, input logic [31:0] b0,
                      input logic [31:0] a1, input logic [31:0] b1,
                      input logic [31:0] c1, input logic [31:0] c2,
                      input int bp, input string tag);
        int         win;
        logic [5:0] exp;
        win = (v0 && v1) ? m_ptr : (v1 ? 1 : 0);
        exp = 6'($countones(win ? (a1 ^ b1) : (a0 ^ b0)));
        istek0_gecerli_i = v0; istek1_gecerli_i = v1;
        istek0_deger1_i = a0;  istek0_deger2_i = b0;
        istek1_deger1_i = a1;  istek1_deger2_i = b1;
        sonuc0_hazir_i = 1'($urandom); sonuc1_hazir_i = 1'($urandom);
        #1;
        check({tag, " grant hazir0"}, 32'(istek0_hazir_o), 32'(win == 0));
        check({tag, " grant hazir1"}, 32'(istek1_hazir_o), 32'(win == 1));
        check({tag, " grant gecerli"}, {30'd0, sonuc1_gecerli_o, sonuc0_gecerli_o}, 0);
        check({tag, " grant sonuc hold"}, 32'(sonuc_o), 32'(m_last));
        m_ptr = 1 - win;
        @(posedge clk_i); @(negedge clk_i);
        istek0_deger1_i = c1; istek0_deger2_i = c2;
        istek1_deger1_i = c1; istek1_deger2_i = c2;
        #1;
        check({tag, " calc hazir"}, {30'd0, istek1_hazir_o, istek0_hazir_o}, 0);
        check({tag, " calc gecerli"}, {30'd0, sonuc1_gecerli_o, sonuc0_gecerli_o}, 0);
        check({tag, " calc sonuc hold"}, 32'(sonuc_o), 32'(m_last));
        @(posedge clk_i); @(negedge clk_i);
        for (int k = 0; k < bp; k++) begin
            // Owner stalls; the other requester's ready must be ignored.
            if (win == 1) begin sonuc1_hazir_i = 1'b0; sonuc0_hazir_i = 1'b1; end
            else          begin sonuc0_hazir_i = 1'b0; sonuc1_hazir_i = 1'b1; end
            #1;
            check({tag, " stall gecerli"}, {30'd0, sonuc1_gecerli_o, sonuc0_gecerli_o},
                  (win == 1) ? 32'd2 : 32'd1);
            check({tag, " stall sonuc"}, 32'(sonuc_o), 32'(exp));
            check({tag, " stall hazir"}, {30'd0, istek1_hazir_o, istek0_hazir_o}, 0);
            @(posedge clk_i); @(negedge clk_i);
        end
        if (win == 1) sonuc1_hazir_i = 1'b1; else sonuc0_hazir_i = 1'b1;
        #1;
        check({tag, " result gecerli"}, {30'd0, sonuc1_gecerli_o, sonuc0_gecerli_o},
              (win == 1) ? 32'd2 : 32'd1);
        check({tag, " result sonuc"}, 32'(sonuc_o), 32'(exp));
        check({tag, " result hazir"}, {30'd0, istek1_hazir_o, istek0_hazir_o}, 0);
        @(posedge clk_i); @(negedge clk_i);
        m_last = exp;
        m_ops++;
        check({tag, " count"}, 32'(islem_sayisi_o), cnt_exp());
        check({tag, " back idle gecerli"}, {30'd0, sonuc1_gecerli_o, sonuc0_gecerli_o}, 0);
    endtask

    initial begin
        logic [1:0] r;
        m_ptr = 0; m_ops = 0; m_last = 6'd0;
        rst_ni = 1'b0;
        istek0_gecerli_i = 1'b1; istek1_gecerli_i = 1'b1;
        istek0_deger1_i = '0; istek0_deger2_i = '0;
        istek1_deger1_i = '0; istek1_deger2_i = '0;
        sonuc0_hazir_i = 1'b0; sonuc1_hazir_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i); #1;
        check("reset hazir", {30'd0, istek1_hazir_o, istek0_hazir_o}, 0);
        check("reset gecerli", {30'd0, sonuc1_gecerli_o, sonuc0_gecerli_o}, 0);
        check("reset sonuc", 32'(sonuc_o), 0);
        check("reset count", 32'(islem_sayisi_o), 0);
        istek0_gecerli_i = 1'b0; istek1_gecerli_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i); #1;
        check("idle hazir", {30'd0, istek1_hazir_o, istek0_hazir_o}, 0);
        check("idle gecerli", {30'd0, sonuc1_gecerli_o, sonuc0_gecerli_o}, 0);
        @(negedge clk_i);

        // Continuous tie after reset: grants 0,1,0,1 / results 1,3
        for (int i = 0; i < 4; i++)
            op(1'b1, 1'b1, 32'h0, 32'h1, 32'h0, 32'h7, 32'h0, 32'h1, 0, "rr");

        // Single op on requester 0, full complement -> 32
        op(1'b1, 1'b0, 32'hFFFF0000, 32'h0000FFFF, 32'h0, 32'h0,
           $urandom, $urandom, 0, "full");

        // Requester 1 wins tie, then stalls 5 cycles with requester 0 waiting
        op(1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, 5, "bp");

        // Operand change after grant must not disturb the result -> 0
        op(1'b1, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'h0,
           32'hFFFFFFFF, 32'h0, 0, "opchg");

        // Randomized traffic
        for (int i = 0; i < 20; i++) begin
            r = 2'($urandom_range(1, 3));
            op(r[0], r[1], $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom_range(0, 3), "rand");
        end
        istek0_gecerli_i = 1'b0; istek1_gecerli_i = 1'b0;
        @(negedge clk_i);

        // Reset while computing
        istek0_gecerli_i = 1'b1; istek1_gecerli_i = 1'b1;
        istek0_deger1_i = 32'h0; istek0_deger2_i = 32'hFF;
        @(posedge clk_i); @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("midrst hazir", {30'd0, istek1_hazir_o, istek0_hazir_o}, 0);
        check("midrst gecerli", {30'd0, sonuc1_gecerli_o, sonuc0_gecerli_o}, 0);
        check("midrst sonuc", 32'(sonuc_o), 0);
        check("midrst count", 32'(islem_sayisi_o), 0);
        m_ptr = 0; m_ops = 0; m_last = 6'd0;
        istek0_gecerli_i = 1'b0; istek1_gecerli_i = 1'b0;
        sonuc0_hazir_i = 1'b1; sonuc1_hazir_i = 1'b1;
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i); #1;
            check("postrst gecerli", {30'd0, sonuc1_gecerli_o, sonuc0_gecerli_o}, 0);
        end
        @(negedge clk_i);
        // Tie after reset goes to requester 0; five ops exercise saturation
        for (int i = 0; i < 5; i++)
            op(1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, 0, "cnt");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/hamming_hakem.md
HAMMING_HAKEM -- requirements
Module: hamming_hakem

Interface
REQ-001 The block SHALL have exactly one parameter: SAYAC_GENISLIGI, default 16, width of the completed-operation counter.
REQ-002 The block SHALL have the ports below, clock and reset first:
- clk_i  input  1  single clock; all state on rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- istek0_gecerli_i  input  1  requester 0 (X-instruction path) has operands.
- istek0_hazir_o  output  1  requester 0 operands accepted this cycle.
- istek0_deger1_i, istek0_deger2_i  input  32 each  requester 0 operands.
- istek1_gecerli_i  input  1  requester 1 (crypto helper) has operands.
- istek1_hazir_o  output  1  requester 1 operands accepted this cycle.
- istek1_deger1_i, istek1_deger2_i  input  32 each  requester 1 operands.
- sonuc0_gecerli_o, sonuc1_gecerli_o  output  1 each  result valid for requester 0/1.
- sonuc0_hazir_i, sonuc1_hazir_i  input  1 each  requester 0/1 takes the result.
- sonuc_o  output  6  hamming distance, 0..32; shared bus.
- islem_sayisi_o  output  SAYAC_GENISLIGI  completed-operation count.

Function
REQ-003 The block SHALL share one instance of the existing hamming_distance datapath between the two requesters.
REQ-004 The FSM SHALL have three states: BOSTA, HESAPLA and SONUC.
REQ-005 In BOSTA with at least one istekN_gecerli_i high, the FSM SHALL grant one requester, assert its istekN_hazir_o combinationally in that cycle, latch both operands and the grant ID, and go to HESAPLA.
REQ-006 istekN_hazir_o SHALL be low in HESAPLA and SONUC, and low for the requester that is not granted.
REQ-007 Arbitration SHALL be round-robin: a 1-bit pointer selects the preferred requester, and the pointer moves to the other requester after every grant.
REQ-008 When only one requester is valid, it SHALL be granted regardless of the pointer.
REQ-009 In HESAPLA, the block SHALL register the datapath output of the latched operands into sonuc_o and go to SONUC.
REQ-010 In SONUC, the block SHALL assert only the granted requester's sonucN_gecerli_o and hold sonuc_o stable.
REQ-011 In SONUC, when the matching sonucN_hazir_i is high, the FSM SHALL return to BOSTA on the next edge.
REQ-012 The non-granted requester's sonucN_hazir_i SHALL be ignored.
REQ-013 Latency: request accepted at edge N SHALL give valid result from edge N+2. Maximum throughput is one operation per 3 cycles.
REQ-014 A new grant SHALL NOT occur in the cycle that the result is consumed.
REQ-015 sonuc_o SHALL hold its last value outside SONUC.
REQ-016 sonuc_o arithmetic SHALL be 6 bits unsigned: identical operands give 0, and fully complementary operands give 32, with no overflow.
REQ-017 Operand inputs SHALL be sampled only in the grant cycle; later operand changes SHALL NOT affect the pending result.

Reset
REQ-018 Asserting rst_ni low SHALL, asynchronously and at any state including mid-operation, set: FSM = BOSTA; pointer = requester 0; sonuc_o = 0; both sonucN_gecerli_o = 0; both istekN_hazir_o = 0; islem_sayisi_o = 0.
REQ-019 A pending operation SHALL be discarded at reset, with no result delivered.
REQ-020 The first grant after reset release SHALL favour requester 0 on a tie.

Configuration
REQ-021 With HAMMING_HAKEM_SAYAC_EN defined, islem_sayisi_o SHALL increment by 1 on each result handshake in SONUC and saturate at all-ones.
REQ-022 Without HAMMING_HAKEM_SAYAC_EN, the counter SHALL not be built and islem_sayisi_o SHALL be tied to 0.

Verification
REQ-023 Req0 single op: deger1=0xFFFF0000, deger2=0x0000FFFF, sonuc0_hazir_i held high -> istek0_hazir_o pulses for 1 cycle; sonuc0_gecerli_o at N+2 with sonuc_o=32; BOSTA at N+3.
REQ-024 Both requesters valid continuously after reset (req0 operands 0x0/0x1, req1 operands 0x0/0x7) -> grants alternate 0,1,0,1; results alternate 1,3; each grant is 3 cycles apart.
REQ-025 Backpressure: sonuc1_hazir_i low for 5 cycles, with req0 valid meanwhile -> sonuc1_gecerli_o and sonuc_o stay stable; istek0_hazir_o stays low until 1 cycle after the handshake.
REQ-026 Operand change: req0 changes operands right after grant (0xA5A5A5A5 vs 0xA5A5A5A5, then 0xFFFFFFFF) -> sonuc_o=0.
REQ-027 Reset in HESAPLA -> all outputs 0 immediately; no sonucN_gecerli_o after release; next tie grants requester 0.
REQ-028 With HAMMING_HAKEM_SAYAC_EN and SAYAC_GENISLIGI=2, run 5 ops -> islem_sayisi_o reads 1,2,3,3,3; without the macro -> islem_sayisi_o stays 0.
